// File: rtl/serial_shift_ctrl_pkg.sv
// Shared encodings and default sizing for the serial shift controller.
package serial_shift_ctrl_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate applied once per controller cycle.
module shift_step
  import serial_shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      OP_ROTR: dout = {din[0], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end
endmodule

// File: rtl/serial_shift_ctrl.sv
// Multi-cycle shifter: latches a request, applies one bit step per cycle,
// then pulses done with the result held in dout until the next completion.
module serial_shift_ctrl
  import serial_shift_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);
  state_t             state, nstate;
  op_t                op_q;
  logic [WIDTH-1:0]   work, stepped;
  logic [SHAMT_W-1:0] cnt;
  logic               last_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .din (work),
    .dout(stepped)
  );

  assign last_step = (cnt == SHAMT_W'(1));

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (start) nstate = (shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_step) nstate = S_DONE;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_SLL;
      work  <= '0;
      cnt   <= '0;
      dout  <= '0;
    end else begin
      state <= nstate;
      case (state)
        S_IDLE: if (start) begin
          work <= din;
          cnt  <= shamt;
          op_q <= op_t'(op);
          // zero-step requests complete straight from the latched operand
          if (shamt == '0) dout <= din;
        end
        S_SHIFT: begin
          work <= stepped;
          cnt  <= cnt - SHAMT_W'(1);
          if (last_step) dout <= stepped;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Directed bench for serial_shift_ctrl: latency, busy window, results, abort.
module tb_serial_shift_ctrl;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = 32'h0;

  serial_shift_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .din(din),
    .shamt(shamt), .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; that cycle is cycle 0. inj>0 fires an
  // ignored start (din=0, shamt=0) during that cycle. Returns at cycle sa+2.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                        input logic [4:0] sa, input logic [31:0] exp, input int inj);
    start = 1'b1; op = o; din = d; shamt = sa;
    for (int c = 1; c <= int'(sa) + 1; c++) begin
      @(negedge clk);
      start = 1'b0; din = 32'hDEAD_BEEF; shamt = 5'd3; op = ~o;
      if (c == inj) begin start = 1'b1; din = 32'h0; shamt = 5'd0; end
      chk({tag, ":busy"}, {31'b0, busy}, 32'd1);
      chk({tag, ":done"}, {31'b0, done}, {31'b0, (c == int'(sa) + 1)});
      chk({tag, ":dout"}, dout, (c == int'(sa) + 1) ? exp : last_res);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, ":idle_done"}, {31'b0, done}, 32'd0);
    chk({tag, ":hold"}, dout, exp);
    last_res = exp;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; din = 32'h0; shamt = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dout", dout, 32'h0);

    run_op("sra4",   2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 0);
    run_op("srl4",   2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 0);
    run_op("sll31",  2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 0);
    run_op("zero",   2'b11, 32'h1234_ABCD, 5'd0,  32'h1234_ABCD, 0);
    run_op("zero_s", 2'b10, 32'h8765_4321, 5'd0,  32'h8765_4321, 0);
    run_op("rotr1",  2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 0);
    run_op("ign",    2'b01, 32'hFF00_0000, 5'd8,  32'h00FF_0000, 3);
    run_op("rotr4",  2'b11, 32'h0000_000F, 5'd4,  32'hF000_0000, 0);
    run_op("sra_p",  2'b10, 32'h4000_0000, 5'd2,  32'h1000_0000, 0);
    run_op("sll1",   2'b00, 32'h8000_0001, 5'd1,  32'h0000_0002, 0);

    // abort: SLL by 10 started in cycle 0, reset asserted in cycle 4
    start = 1'b1; op = 2'b00; din = 32'h0000_0001; shamt = 5'd10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy5", {31'b0, busy}, 32'd0);
    chk("abort_done5", {31'b0, done}, 32'd0);
    chk("abort_dout5", dout, 32'h0);
    last_res = 32'h0;
    @(negedge clk);
    chk("abort_done6", {31'b0, done}, 32'd0);
    run_op("post_rst", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 0);

    // reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; op = 2'b01; din = 32'hFFFF_FFFF; shamt = 5'd0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("prio_busy", {31'b0, busy}, 32'd0);
    chk("prio_done", {31'b0, done}, 32'd0);
    chk("prio_dout", dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_shift_ctrl.md
SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, giving the shift-amount width; the value is log2(WIDTH).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: request a new shift; sampled on the rising edge.
REQ-006 Port op, input, 2: operation; 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
REQ-007 Port din, input, WIDTH: operand.
REQ-008 Port shamt, input, SHAMT_W: shift amount, unsigned.
REQ-009 Port busy, output, 1: high while an operation is in progress (state != IDLE).
REQ-010 Port done, output, 1: one-cycle pulse marking dout valid.
REQ-011 Port dout, output, WIDTH: result register.

Function
REQ-012 The controller SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch din into the working register, shamt into the counter, and op into an op register. It SHALL go to DONE if shamt==0, otherwise to SHIFT.
REQ-014 In SHIFT, each edge SHALL apply exactly one 1-bit step of the latched op to the working register and decrement the counter. When the counter goes from 1 to 0, the next state SHALL be DONE.
REQ-015 One-bit step rules:
- SLL: shift left, fill 0.
- SRL: shift right, fill 0.
- SRA: shift right, fill the current MSB (sign-preserving).
- ROTR: rotate right, LSB to MSB.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle and dout SHALL equal the final working register. The next state SHALL be IDLE unconditionally.
REQ-017 Latency: start sampled at the end of cycle 0 SHALL give done=1 in cycle shamt+1. This holds for all shamt, including 0.
REQ-018 busy SHALL be 1 in every cycle from cycle 1 through cycle shamt+1 inclusive, and 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE. No queuing: a request arriving then is lost, and the requester must retry in IDLE.
REQ-020 Back-to-back: the earliest next accepted start SHALL be sampled in the first IDLE cycle after DONE.
REQ-021 dout SHALL hold its value from DONE until the DONE of the next operation; it SHALL NOT change during SHIFT.
REQ-022 din, shamt and op SHALL be don't-care after the accepting edge; the result depends only on the latched values.
REQ-023 shamt=WIDTH-1 SHALL be supported (31 steps at default); no modulo beyond SHAMT_W bits.

Reset
REQ-024 reset=1 at an edge SHALL force state=IDLE, busy=0, done=0, dout=0, counter=0 and working register=0, regardless of state.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-026 reset SHALL take priority over start on the same edge.

Structure
REQ-027 A shared package SHALL hold:
- op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROTR;
- state encodings S_IDLE, S_SHIFT, S_DONE;
- default WIDTH and SHAMT_W constants.
REQ-028 The one-bit step SHALL be a combinational sub-module, shift_step (inputs op and data, output data), instantiated once.
REQ-029 No multi-bit barrel shifter SHALL be used; one step per cycle only.

Verification
REQ-030 SRA, din=0x80000000, shamt=4, start in cycle 0 -> dout=0xF8000000 and done=1 in cycle 5; busy=1 in cycles 1-5.
REQ-031 SRL, din=0x80000000, shamt=4 -> dout=0x08000000, done in cycle 5. Separately, SLL, din=0x00000001, shamt=31 -> dout=0x80000000, done in cycle 32.
REQ-032 shamt=0, any op, din=0x1234ABCD -> dout=0x1234ABCD, done in cycle 1, single pulse. Separately, ROTR, din=0x00000001, shamt=1 -> dout=0x80000000.
REQ-033 Start SRL shamt=8 on 0xFF000000; pulse start with din=0 in cycle 3 -> ignored; dout=0x00FF0000, done in cycle 9.
REQ-034 Start SLL shamt=10; assert reset in cycle 4 -> busy=0, done=0, dout=0 from cycle 5; no done pulse afterwards. Then a start in cycle 6 SHALL operate normally.
